// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: takes the rasterizer pixel stream, clips it to the screen,
// queues {address, color} in a small FIFO and commits each entry to the
// framebuffer through a req/ack write port. It also reports when every pixel
// of a triangle has been committed.
// Optional feature macro: FB_CLEAR_EN adds a full-screen clear engine, with
// ports in_sig_clear and in_clear_color and a CLEAR state.
//
// Memory handshake: out_mem_we is the request (valid). While it is high,
// out_mem_addr and out_mem_data stay stable. A rising edge that sees
// in_mem_ack=1 completes the transfer. The next request may be presented in
// the cycle right after that edge. in_mem_ack is ignored while out_mem_we=0.
// The entry being presented stays in the FIFO until its ack edge, so FIFO
// occupancy counts the write in flight.
module fb_pixel_writer #(
  parameter int SCREEN_W    = 320,
  parameter int SCREEN_H    = 240,
  parameter int ADDR_W      = 17,
  parameter int FIFO_AW     = 3,
  parameter int STALL_LEVEL = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_sig_write_pixel,
  input  logic [15:0]       in_pixel_x,
  input  logic [15:0]       in_pixel_y,
  input  logic [15:0]       in_pixel_color,
  input  logic              in_sig_rasterize_done,
`ifdef FB_CLEAR_EN
  input  logic              in_sig_clear,
  input  logic [15:0]       in_clear_color,
`endif
  output logic              out_sig_stall,
  output logic              out_sig_overflow,
  output logic              out_sig_writes_done,
  output logic              out_sig_busy,
  output logic              out_mem_we,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic [15:0]       out_mem_data,
  input  logic              in_mem_ack,
  output logic [1:0]        dbg_state
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNT_W = FIFO_AW + 1;
  localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]   STALL_C = CNT_W'(STALL_LEVEL);
  localparam logic [CNT_W-1:0]   ONE_C   = CNT_W'(1);
  localparam logic [15:0]        W16     = 16'(SCREEN_W);
  localparam logic [15:0]        H16     = 16'(SCREEN_H);
  localparam logic [ADDR_W-1:0]  W_A     = ADDR_W'(SCREEN_W);
`ifdef FB_CLEAR_EN
  localparam logic [ADDR_W-1:0]  LAST_A  = ADDR_W'(SCREEN_W * SCREEN_H - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1
`ifdef FB_CLEAR_EN
    ,ST_CLEAR = 2'd2
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]   fifo_addr_q [DEPTH];
  logic [15:0]         fifo_color_q [DEPTH];
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [15:0]         mem_data_q, mem_data_d;
  logic                stall_q, stall_d;
  logic                overflow_q, overflow_d;
  logic                done_pending_q, done_pending_d;
  logic                writes_done_q, writes_done_d;
  logic                on_screen, push, pop, fire, clear_active_d;
  logic [ADDR_W-1:0]   push_addr;
`ifdef FB_CLEAR_EN
  logic                clear_pending_q, clear_pending_d;
  logic [15:0]         clear_color_q, clear_color_d;
  logic                clear_start;
`endif

  // Input stage: clip, address computation and FIFO admission / overflow.
  always_comb begin
    on_screen  = (in_pixel_x < W16) && (in_pixel_y < H16);
    push_addr  = ADDR_W'(in_pixel_y) * W_A + ADDR_W'(in_pixel_x);
    push       = in_sig_write_pixel && on_screen && ((count_q != DEPTH_C) || pop);
    overflow_d = overflow_q ||
                 (in_sig_write_pixel && on_screen && (count_q == DEPTH_C) && !pop);
  end

  // Write FSM: presents the FIFO head (or clear addresses) and advances on ack.
  always_comb begin
    state_d    = state_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    pop        = 1'b0;
    rd_next    = rd_ptr_q + FIFO_AW'(1);
`ifdef FB_CLEAR_EN
    clear_start = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          mem_we_d   = 1'b1;
          mem_addr_d = fifo_addr_q[rd_ptr_q];
          mem_data_d = fifo_color_q[rd_ptr_q];
          state_d    = ST_WRITE;
        end
`ifdef FB_CLEAR_EN
        else if (clear_pending_q) begin
          clear_start = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = '0;
          mem_data_d  = clear_color_q;
          state_d     = ST_CLEAR;
        end
`endif
      end
      ST_WRITE: begin
        if (in_mem_ack) begin
          pop = 1'b1;
          if (count_q > ONE_C) begin
            mem_addr_d = fifo_addr_q[rd_next];
            mem_data_d = fifo_color_q[rd_next];
          end else begin
            mem_we_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end
      end
`ifdef FB_CLEAR_EN
      ST_CLEAR: begin
        if (in_mem_ack) begin
          if (mem_addr_q == LAST_A) begin
            mem_we_d = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
          end
        end
      end
`endif
      default: begin
        mem_we_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // FIFO pointers, occupancy and the registered stall level.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_next : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
`ifdef FB_CLEAR_EN
    clear_active_d = (state_d == ST_CLEAR);
`else
    clear_active_d = 1'b0;
`endif
    stall_d = (count_d >= STALL_C) || clear_active_d;
  end

  // Completion: pulse once when the triangle's pixels have all been committed.
  always_comb begin
    fire = done_pending_q && (count_q == '0) && !mem_we_q && !push;
`ifdef FB_CLEAR_EN
    fire = fire && !clear_pending_q && (state_q != ST_CLEAR);
`endif
    done_pending_d = fire ? 1'b0 : (done_pending_q || in_sig_rasterize_done);
    writes_done_d  = fire;
  end

`ifdef FB_CLEAR_EN
  // Clear request latch: a new request during a running clear queues another one.
  always_comb begin
    clear_pending_d = clear_start ? 1'b0 : clear_pending_q;
    clear_color_d   = clear_color_q;
    if (in_sig_clear) begin
      clear_pending_d = 1'b1;
      clear_color_d   = in_clear_color;
    end
  end
`endif

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_q     <= '0;
      stall_q        <= 1'b0;
      overflow_q     <= 1'b0;
      done_pending_q <= 1'b0;
      writes_done_q  <= 1'b0;
`ifdef FB_CLEAR_EN
      clear_pending_q <= 1'b0;
      clear_color_q   <= '0;
`endif
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_q     <= mem_data_d;
      stall_q        <= stall_d;
      overflow_q     <= overflow_d;
      done_pending_q <= done_pending_d;
      writes_done_q  <= writes_done_d;
`ifdef FB_CLEAR_EN
      clear_pending_q <= clear_pending_d;
      clear_color_q   <= clear_color_d;
`endif
    end
  end

  // FIFO storage; contents are don't-care until the pointers mark them valid.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q]  <= push_addr;
      fifo_color_q[wr_ptr_q] <= in_pixel_color;
    end
  end

  assign out_mem_we          = mem_we_q;
  assign out_mem_addr        = mem_addr_q;
  assign out_mem_data        = mem_data_q;
  assign out_sig_stall       = stall_q;
  assign out_sig_overflow    = overflow_q;
  assign out_sig_writes_done = writes_done_q;
  assign dbg_state           = state_q;
`ifdef FB_CLEAR_EN
  assign out_sig_busy = (count_q != '0) || mem_we_q || clear_pending_q || (state_q == ST_CLEAR);
`else
  assign out_sig_busy = (count_q != '0) || mem_we_q;
`endif

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer: directed vectors with hand-computed addresses.
// With FB_CLEAR_EN defined, a second small-screen instance exercises the clear.
module tb_fb_pixel_writer;

  localparam int AW = 17;
  localparam int W  = AW + 16;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          wr_pix, done_in, mem_ack;
  logic [15:0]   px, py, pcolor;
  logic          stall, overflow, writes_done, busy, mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data;
  logic [1:0]    dbg_state;

  fb_pixel_writer dut (
    .clock                 (clock),
    .reset                 (reset),
    .in_sig_write_pixel    (wr_pix),
    .in_pixel_x            (px),
    .in_pixel_y            (py),
    .in_pixel_color        (pcolor),
    .in_sig_rasterize_done (done_in),
`ifdef FB_CLEAR_EN
    .in_sig_clear          (1'b0),
    .in_clear_color        (16'h0000),
`endif
    .out_sig_stall         (stall),
    .out_sig_overflow      (overflow),
    .out_sig_writes_done   (writes_done),
    .out_sig_busy          (busy),
    .out_mem_we            (mem_we),
    .out_mem_addr          (mem_addr),
    .out_mem_data          (mem_data),
    .in_mem_ack            (mem_ack),
    .dbg_state             (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int last_wr_cyc = 0;
  int wr_gap = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clock) cyc++;

  // Transfers are observed mid-cycle: inputs only change just after posedge.
  always @(negedge clock) begin
    if (!reset && mem_we && mem_ack) begin
      wr_cnt++;
      wr_gap = cyc - last_wr_cyc;
      last_wr_cyc = cyc;
      check("write_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) check("write", 64'({mem_addr, mem_data}), 64'(exp_q.pop_front()));
    end
    if (!reset && writes_done) begin
      done_cnt++;
      check("commit_before_done", 64'(exp_q.size()), 64'(0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_pixel(input logic [15:0] x, input logic [15:0] y, input logic [15:0] c);
    wr_pix = 1'b1; px = x; py = y; pcolor = c;
    tick();
    wr_pix = 1'b0;
  endtask

  function automatic logic [W-1:0] ent(input int addr, input logic [15:0] c);
    return {AW'(addr), c};
  endfunction

`ifdef FB_CLEAR_EN
  // ---------------- small-screen clear instance ----------------
  logic          c_clear, c_stall, c_overflow, c_done, c_busy, c_we;
  logic [AW-1:0] c_addr;
  logic [15:0]   c_data;
  logic [1:0]    c_state;
  logic [W-1:0]  exp_c_q[$];

  fb_pixel_writer #(.SCREEN_W(4), .SCREEN_H(2)) dut_c (
    .clock                 (clock),
    .reset                 (reset),
    .in_sig_write_pixel    (1'b0),
    .in_pixel_x            (16'h0000),
    .in_pixel_y            (16'h0000),
    .in_pixel_color        (16'h0000),
    .in_sig_rasterize_done (1'b0),
    .in_sig_clear          (c_clear),
    .in_clear_color        (16'h001F),
    .out_sig_stall         (c_stall),
    .out_sig_overflow      (c_overflow),
    .out_sig_writes_done   (c_done),
    .out_sig_busy          (c_busy),
    .out_mem_we            (c_we),
    .out_mem_addr          (c_addr),
    .out_mem_data          (c_data),
    .in_mem_ack            (1'b1),
    .dbg_state             (c_state)
  );

  always @(negedge clock) begin
    if (!reset && c_we) begin
      check("clr_write_expected", 64'(exp_c_q.size() != 0), 64'(1));
      if (exp_c_q.size() != 0) check("clr_write", 64'({c_addr, c_data}), 64'(exp_c_q.pop_front()));
    end
  end
`endif

  // ---------------- directed sequence ----------------
  int base;
  initial begin
    wr_pix = 1'b0; done_in = 1'b0; mem_ack = 1'b0;
    px = '0; py = '0; pcolor = '0;
`ifdef FB_CLEAR_EN
    c_clear = 1'b0;
`endif
    #2;
    check("rst_stall", 64'(stall), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_done", 64'(writes_done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_we", 64'(mem_we), 64'(0));
    tick(); tick();
    reset = 1'b0;
    tick();

    // Test 1: two adjacent pixels back-to-back, then a repeated done.
    mem_ack = 1'b1;
    exp_q.push_back(ent(643, 16'hF800));
    exp_q.push_back(ent(644, 16'h07E0));
    drive_pixel(16'd3, 16'd2, 16'hF800);
    drive_pixel(16'd4, 16'd2, 16'h07E0);
    done_in = 1'b1; tick(); tick(); done_in = 1'b0;
    repeat (6) tick();
    check("t1_writes", 64'(wr_cnt), 64'(2));
    check("t1_back_to_back", 64'(wr_gap), 64'(1));
    check("t1_single_done", 64'(done_cnt), 64'(1));
    check("t1_drained", 64'(exp_q.size()), 64'(0));

    // Test 2: memory stalled while 10 pixels stream in.
    mem_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) exp_q.push_back(ent(3200 + i, 16'hA000 + 16'(i)));
      drive_pixel(16'(i), 16'd10, 16'hA000 + 16'(i));
      if (i == 4) check("t2_stall_below", 64'(stall), 64'(0));
      if (i == 5) check("t2_stall_at_6", 64'(stall), 64'(1));
    end
    check("t2_overflow", 64'(overflow), 64'(1));
    check("t2_stall_full", 64'(stall), 64'(1));
    repeat (10) tick();
    check("t2_held_we", 64'(mem_we), 64'(1));
    check("t2_held_addr", 64'(mem_addr), 64'(3200));
    base = wr_cnt;
    mem_ack = 1'b1;
    repeat (12) tick();
    check("t2_drain_count", 64'(wr_cnt - base), 64'(8));
    check("t2_drained", 64'(exp_q.size()), 64'(0));
    check("t2_overflow_sticky", 64'(overflow), 64'(1));
    check("t2_stall_released", 64'(stall), 64'(0));

    // Test 5: reset in the middle of a pending request.
    mem_ack = 1'b0;
    for (int i = 0; i < 7; i++) drive_pixel(16'(i), 16'd0, 16'h5555);
    tick();
    check("t5_pre_we", 64'(mem_we), 64'(1));
    check("t5_pre_stall", 64'(stall), 64'(1));
    reset = 1'b1;
    #1;
    check("t5_async_we", 64'(mem_we), 64'(0));
    check("t5_async_stall", 64'(stall), 64'(0));
    check("t5_async_busy", 64'(busy), 64'(0));
    check("t5_async_overflow", 64'(overflow), 64'(0));
    tick(); tick();
    reset = 1'b0;
    base = wr_cnt;
    mem_ack = 1'b1;
    repeat (5) tick();
    check("t5_fifo_empty", 64'(busy), 64'(0));
    check("t5_no_writes", 64'(wr_cnt - base), 64'(0));

    // Test 3: clipped pixels, then done on an empty pipe.
    base = wr_cnt;
    drive_pixel(16'd320, 16'd0, 16'h1111);
    drive_pixel(16'd0, 16'd240, 16'h2222);
    drive_pixel(16'hFFFF, 16'd5, 16'h3333);
    tick();
    check("t3_busy", 64'(busy), 64'(0));
    check("t3_overflow", 64'(overflow), 64'(0));
    done_in = 1'b1; tick(); done_in = 1'b0;
    check("t3_done_not_yet", 64'(writes_done), 64'(0));
    tick();
    check("t3_done_pulse", 64'(writes_done), 64'(1));
    tick();
    check("t3_done_one_cycle", 64'(writes_done), 64'(0));
    check("t3_no_writes", 64'(wr_cnt - base), 64'(0));

    // Test 4: last pixel together with done, ack late.
    mem_ack = 1'b0;
    base = done_cnt;
    exp_q.push_back(ent(330, 16'h1234));
    done_in = 1'b1;
    drive_pixel(16'd10, 16'd1, 16'h1234);
    done_in = 1'b0;
    repeat (3) tick();
    check("t4_no_early_done", 64'(done_cnt - base), 64'(0));
    check("t4_req_pending", 64'(mem_we), 64'(1));
    mem_ack = 1'b1;
    tick();
    check("t4_done_after_ack", 64'(writes_done), 64'(0));
    tick();
    check("t4_done_pulse", 64'(writes_done), 64'(1));
    tick();
    check("t4_done_count", 64'(done_cnt - base), 64'(1));
    check("t4_drained", 64'(exp_q.size()), 64'(0));

`ifdef FB_CLEAR_EN
    // Test 6: clear of a 4x2 screen.
    for (int i = 0; i < 8; i++) exp_c_q.push_back(ent(i, 16'h001F));
    c_clear = 1'b1; tick(); c_clear = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      check("t6_stall", 64'(c_stall), 64'(1));
      tick();
    end
    check("t6_idle", 64'(c_state), 64'(0));
    check("t6_stall_low", 64'(c_stall), 64'(0));
    check("t6_all_written", 64'(exp_c_q.size()), 64'(0));
    check("t6_no_overflow", 64'(c_overflow), 64'(0));
    check("t6_no_done", 64'(c_done), 64'(0));
    check("t6_not_busy", 64'(c_busy), 64'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
